// File: rtl/ejer2_sysid_chk_pkg.sv
// Shared types and constants for the system-ID checker.
// Word addresses of the system-ID slave and counter width.
package ejer2_sysid_chk_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_COMPARE,
        S_WAIT
    } state_t;

    localparam int   CNT_W   = 16;
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/ejer2_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module ejer2_sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ejer2_sysid_checker.sv
// Avalon-MM read master that checks the system-ID and build timestamp
// words against build-time constants and publishes pass/fail status.
module ejer2_sysid_checker
    import ejer2_sysid_chk_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID   = 32'd0,
    parameter logic [31:0] EXPECTED_TS   = 32'd1434116220,
    parameter int          POLL_INTERVAL = 1000000,
    parameter int          TIMEOUT       = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    output logic             busy,
    output logic             done,
    output logic             id_ok,
    output logic             ts_ok,
    output logic             timeout_err,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] mismatch_count
);

    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [31:0] POLL_LOAD =
        (POLL_INTERVAL > 0) ? 32'(POLL_INTERVAL - 1) : 32'd0;

    state_t      state;
    state_t      state_n;
    logic        pending;
    logic        abort;
    logic [15:0] stall;
    logic [31:0] poll;
    logic [31:0] id_q;
    logic [31:0] ts_q;
    logic        reading;
    logic        stall_out;
    logic        id_hit;
    logic        ts_hit;
    logic        in_cmp;

    assign reading     = (state == S_RD_ID) || (state == S_RD_TS);
    assign avm_read    = reading;
    assign avm_address = (state == S_RD_TS) ? ADDR_TS : ADDR_ID;
    assign busy        = reading || (state == S_COMPARE);
    assign in_cmp      = (state == S_COMPARE);

    // Last tolerated stall: this waitrequest cycle makes the count hit TIMEOUT.
    assign stall_out = avm_waitrequest && (stall == TO_LAST);
    assign id_hit    = (id_q == EXPECTED_ID) && !abort;
    assign ts_hit    = (ts_q == EXPECTED_TS) && !abort;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (pending || start) state_n = S_RD_ID;
            end
            S_RD_ID: begin
                if (!avm_waitrequest) state_n = S_RD_TS;
                else if (stall_out)   state_n = S_COMPARE;
            end
            S_RD_TS: begin
                if (!avm_waitrequest || stall_out) state_n = S_COMPARE;
            end
            S_COMPARE: begin
                state_n = (POLL_INTERVAL > 0) ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (start || (poll == 32'd0)) state_n = S_RD_ID;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pending     <= 1'b1;
            abort       <= 1'b0;
            stall       <= '0;
            poll        <= '0;
            id_q        <= '0;
            ts_q        <= '0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            if (state_n != state) begin
                stall <= '0;
            end else if (reading && avm_waitrequest) begin
                stall <= stall + 16'd1;
            end
            unique case (state)
                S_IDLE: begin
                    if (pending || start) pending <= 1'b0;
                end
                S_RD_ID: begin
                    if (!avm_waitrequest) id_q  <= avm_readdata;
                    else if (stall_out)   abort <= 1'b1;
                end
                S_RD_TS: begin
                    if (!avm_waitrequest) ts_q  <= avm_readdata;
                    else if (stall_out)   abort <= 1'b1;
                end
                S_COMPARE: begin
                    id_ok       <= id_hit;
                    ts_ok       <= ts_hit;
                    timeout_err <= abort;
                    abort       <= 1'b0;
                    done        <= 1'b1;
                    poll        <= POLL_LOAD;
                end
                S_WAIT: begin
                    if (poll != 32'd0) poll <= poll - 32'd1;
                end
                default: ;
            endcase
        end
    end

    ejer2_sat_counter #(.W(CNT_W)) u_check_cnt (
        .clock (clock),
        .clear (reset),
        .inc   (in_cmp),
        .count (check_count)
    );

    ejer2_sat_counter #(.W(CNT_W)) u_mismatch_cnt (
        .clock (clock),
        .clear (reset),
        .inc   (in_cmp && !(id_hit && ts_hit)),
        .count (mismatch_count)
    );

endmodule

// File: tb/tb_ejer2_sysid_checker.sv
// Directed bench for the system-ID checker with a small Avalon slave
// whose stall length and timestamp word are set per scenario.
module tb_ejer2_sysid_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [15:0] check_count;
    logic [15:0] mismatch_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] id_data;
    logic [31:0] ts_data;
    int          ws_n;
    logic        stuck;
    int          wcnt;

    always #5 clock = ~clock;

    // Slave: stalls ws_n cycles per read, or forever when stuck.
    assign avm_waitrequest = stuck | (avm_read & (wcnt < ws_n));
    assign avm_readdata    = avm_address ? ts_data : id_data;

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
        else                              wcnt <= 0;
    end

    ejer2_sysid_checker #(
        .EXPECTED_ID   (32'd0),
        .EXPECTED_TS   (32'd1434116220),
        .POLL_INTERVAL (10),
        .TIMEOUT       (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .check_count     (check_count),
        .mismatch_count  (mismatch_count)
    );

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Returns the index of the edge (0 = first edge after the call) where done shows.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic gap_to_read(output int n);
        n = -1;
        for (int i = 1; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (avm_read) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%0b exp=0", avm_read); end
        checks++; if (avm_address !== 1'b0) begin failures++; $display("FAIL rst_addr got=%0b exp=0", avm_address); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
        checks++; if ({id_ok, ts_ok, timeout_err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {id_ok, ts_ok, timeout_err}); end
        checks++; if (check_count !== 16'd0) begin failures++; $display("FAIL rst_cc got=%0d exp=0", check_count); end
        checks++; if (mismatch_count !== 16'd0) begin failures++; $display("FAIL rst_mc got=%0d exp=0", mismatch_count); end
    endtask

    task automatic test_nominal();
        int e;
        apply_reset();
        @(posedge clock);
        #1;
        checks++; if ({avm_read, avm_address} !== 2'b10) begin failures++; $display("FAIL nom_rdid got=%b exp=10", {avm_read, avm_address}); end
        @(posedge clock);
        #1;
        checks++; if ({avm_read, avm_address} !== 2'b11) begin failures++; $display("FAIL nom_rdts got=%b exp=11", {avm_read, avm_address}); end
        wait_done(e);
        checks++; if (e !== 1) begin failures++; $display("FAIL nom_done_edge got=%0d exp=3", e + 2); end
        checks++; if ({id_ok, ts_ok, timeout_err} !== 3'b110) begin failures++; $display("FAIL nom_flags got=%b exp=110", {id_ok, ts_ok, timeout_err}); end
        checks++; if (check_count !== 16'd1) begin failures++; $display("FAIL nom_cc got=%0d exp=1", check_count); end
        checks++; if (mismatch_count !== 16'd0) begin failures++; $display("FAIL nom_mc got=%0d exp=0", mismatch_count); end
    endtask

    task automatic test_ts_mismatch();
        int e;
        ts_data = 32'h1234_5678;
        apply_reset();
        wait_done(e);
        checks++; if (e !== 3) begin failures++; $display("FAIL mis_done_edge got=%0d exp=3", e); end
        checks++; if ({id_ok, ts_ok, timeout_err} !== 3'b100) begin failures++; $display("FAIL mis_flags got=%b exp=100", {id_ok, ts_ok, timeout_err}); end
        checks++; if (mismatch_count !== 16'd1) begin failures++; $display("FAIL mis_mc got=%0d exp=1", mismatch_count); end
        checks++; if (check_count !== 16'd1) begin failures++; $display("FAIL mis_cc got=%0d exp=1", check_count); end
        ts_data = 32'd1434116220;
    endtask

    task automatic test_stall();
        logic exp_rd;
        logic exp_ad;
        logic exp_dn;
        ws_n = 3;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            exp_rd = (i <= 7);
            exp_ad = (i >= 4) && (i <= 7);
            exp_dn = (i == 9);
            checks++; if ({avm_read, avm_address, done} !== {exp_rd, exp_ad, exp_dn}) begin failures++; $display("FAIL stall_edge%0d got=%b exp=%b", i, {avm_read, avm_address, done}, {exp_rd, exp_ad, exp_dn}); end
        end
        checks++; if ({id_ok, ts_ok, timeout_err} !== 3'b110) begin failures++; $display("FAIL stall_flags got=%b exp=110", {id_ok, ts_ok, timeout_err}); end
        checks++; if (mismatch_count !== 16'd0) begin failures++; $display("FAIL stall_mc got=%0d exp=0", mismatch_count); end
        ws_n = 0;
    endtask

    task automatic test_timeout();
        stuck = 1'b1;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            checks++; if ({avm_read, done} !== {i <= 3, i == 5}) begin failures++; $display("FAIL to_edge%0d got=%b exp=%b", i, {avm_read, done}, {i <= 3, i == 5}); end
        end
        checks++; if ({id_ok, ts_ok, timeout_err} !== 3'b001) begin failures++; $display("FAIL to_flags got=%b exp=001", {id_ok, ts_ok, timeout_err}); end
        checks++; if (mismatch_count !== 16'd1) begin failures++; $display("FAIL to_mc got=%0d exp=1", mismatch_count); end
        stuck = 1'b0;
    endtask

    task automatic test_poll();
        int e;
        int n;
        apply_reset();
        wait_done(e);
        gap_to_read(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL poll_gap got=%0d exp=10", n); end
        wait_done(e);
        checks++; if (check_count !== 16'd2) begin failures++; $display("FAIL poll_cc got=%0d exp=2", check_count); end
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        checks++; if ({avm_read, avm_address} !== 2'b10) begin failures++; $display("FAIL poll_preempt got=%b exp=10", {avm_read, avm_address}); end
        @(negedge clock);
        @(posedge clock);
        #1;
        start = 1'b0;
        checks++; if ({avm_read, avm_address} !== 2'b11) begin failures++; $display("FAIL busy_start got=%b exp=11", {avm_read, avm_address}); end
        wait_done(e);
        checks++; if (e !== 1) begin failures++; $display("FAIL preempt_done got=%0d exp=1", e); end
        checks++; if (check_count !== 16'd3) begin failures++; $display("FAIL preempt_cc got=%0d exp=3", check_count); end
        gap_to_read(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL busy_gap got=%0d exp=10", n); end
    endtask

    task automatic test_reset_mid();
        int e;
        int n;
        apply_reset();
        wait_done(e);
        gap_to_read(n);
        @(posedge clock);
        #1;
        checks++; if ({avm_read, avm_address} !== 2'b11) begin failures++; $display("FAIL mid_rdts got=%b exp=11", {avm_read, avm_address}); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if ({avm_read, avm_address, busy, done} !== 4'b0000) begin failures++; $display("FAIL mid_bus got=%b exp=0000", {avm_read, avm_address, busy, done}); end
        checks++; if ({id_ok, ts_ok, timeout_err} !== 3'b000) begin failures++; $display("FAIL mid_flags got=%b exp=000", {id_ok, ts_ok, timeout_err}); end
        checks++; if (check_count !== 16'd0) begin failures++; $display("FAIL mid_cc got=%0d exp=0", check_count); end
        @(negedge clock);
        reset = 1'b0;
        wait_done(e);
        checks++; if (e !== 3) begin failures++; $display("FAIL mid_restart got=%0d exp=3", e); end
        checks++; if ({id_ok, ts_ok, check_count} !== {2'b11, 16'd1}) begin failures++; $display("FAIL mid_result got=%h exp=%h", {id_ok, ts_ok, check_count}, {2'b11, 16'd1}); end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        id_data = 32'd0;
        ts_data = 32'd1434116220;
        ws_n    = 0;
        stuck   = 1'b0;
        test_reset();
        test_nominal();
        test_ts_mismatch();
        test_stall();
        test_timeout();
        test_poll();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ejer2_sysid_checker.md
# ejer2_sysid_checker

Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its two words: address 0 (system ID) and address 1 (build timestamp). After reset, on a `start` pulse, and optionally at a fixed poll interval, it reads both words and compares them against build-time expected values. It publishes sticky pass/fail flags and saturating counters so firmware or a board LED can confirm the loaded FPGA image matches the software build.

## Interface
- `EXPECTED_ID`, default 0: expected word at address 0.
- `EXPECTED_TS`, default 1434116220: expected word at address 1.
- `POLL_INTERVAL`, default 1000000: cycles spent in WAIT between checks. Value 0 disables periodic re-checking.
- `TIMEOUT`, default 255: maximum consecutive `avm_waitrequest` cycles tolerated per read. Range 1..65535.

Ports:
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request for an immediate check.
- `avm_address`  out  1  word select: 0 = ID, 1 = timestamp.
- `avm_read`  out  1  read strobe.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  read data, valid when `avm_read && !avm_waitrequest` (zero read latency).
- `busy`  out  1  high in RD_ID, RD_TS and COMPARE.
- `done`  out  1  one-cycle pulse at the end of each check.
- `id_ok`  out  1  last check: ID matched.
- `ts_ok`  out  1  last check: timestamp matched.
- `timeout_err`  out  1  last check aborted on timeout.
- `check_count`  out  16  completed checks, saturating.
- `mismatch_count`  out  16  failed checks (mismatch or timeout), saturating.

## Operation
- FSM states: IDLE, RD_ID, RD_TS, COMPARE, WAIT.
- Reset values:
  - state IDLE; internal `pending` flag = 1.
  - All outputs 0: `avm_address`, `avm_read`, `busy`, `done`, `id_ok`, `ts_ok`, `timeout_err`, both counters.
- IDLE: if `pending` or `start`, go to RD_ID and clear `pending`.
- RD_ID: `avm_address`=0, `avm_read`=1.
  - On `!avm_waitrequest`, capture `avm_readdata` into `id_q` and go to RD_TS.
- RD_TS: `avm_address`=1, `avm_read`=1.
  - On `!avm_waitrequest`, capture into `ts_q` and go to COMPARE.
- Timeout:
  - A 16-bit stall counter clears on every state entry and increments on each RD_* cycle with `avm_waitrequest`=1.
  - When it reaches TIMEOUT, drop `avm_read` the next cycle, set an abort flag and go to COMPARE.
- COMPARE (one cycle):
  - `id_ok` = (`id_q`==EXPECTED_ID) && !abort.
  - `ts_ok` = (`ts_q`==EXPECTED_TS) && !abort.
  - `timeout_err` = abort.
  - Pulse `done`.
  - `check_count`+1.
  - `mismatch_count`+1 if !(`id_ok` && `ts_ok`).
  - Next state: WAIT if POLL_INTERVAL>0, else IDLE.
- WAIT:
  - Down-counter loaded with POLL_INTERVAL-1 on entry.
  - Go to RD_ID when the counter reaches 0 or `start`=1, whichever comes first.
- `start` in RD_ID, RD_TS or COMPARE is ignored (not queued).
- Counters stop at 0xFFFF and never wrap.
- Result flags hold their values until the next COMPARE. They are not cleared on entering RD_ID.
- `avm_address` and `avm_read` are Moore outputs of the state register. Address stays stable for the whole stalled read.

## Timing
- `start` sampled in IDLE at edge N:
  - RD_ID during cycle N+1.
  - With zero waitrequest, RD_TS at N+2 and COMPARE at N+3.
  - `done` and updated flags/counters are visible from N+4.
- First check after reset: reset low at edge R gives RD_ID in cycle R+1 and `done` at R+4.
- Each waitrequest cycle adds exactly one cycle of latency.
- Timeout path: `avm_read` is low in the cycle after the TIMEOUT-th stall cycle, and `done` follows one cycle later.
- Reset asserted mid-read: `avm_read` is 0 from the next edge, all flags and counters clear, `pending` is set, and the check restarts cleanly after release.

## Structure
- Package `ejer2_sysid_chk_pkg` holds:
  - the state enum;
  - `CNT_W`=16;
  - constants `ADDR_ID`=0 and `ADDR_TS`=1.
- One sub-module: `ejer2_sat_counter`, a parameterised width counter with increment and synchronous clear that saturates at all-ones. It is instantiated twice for `check_count` and `mismatch_count`.
- The stall and poll counters stay inline.

## Test plan
- Reset release with a zero-wait slave returning 0 and 1434116220 -> `done` at R+4; `id_ok`=`ts_ok`=1, `timeout_err`=0, `check_count`=1, `mismatch_count`=0.
- Slave returns timestamp 0x12345678 -> `ts_ok`=0, `id_ok`=1, `mismatch_count`=1.
- Waitrequest held 3 cycles on each read -> `done` at R+10; address stays stable during stalls; data captured correctly.
- Waitrequest stuck high, TIMEOUT=4 -> `avm_read` drops after 4 stall cycles; `timeout_err`=1, `id_ok`=`ts_ok`=0, `mismatch_count`=1.
- POLL_INTERVAL=10 -> second check starts 10 cycles after the first COMPARE; `start` in WAIT preempts the wait; `start` while `busy` is ignored.
- Reset asserted in RD_TS -> all outputs 0 the next cycle; a fresh check completes after release.
